// File: rtl/key_matrix_scan.sv
// Matrix keypad scanner: 2-flop row synchroniser, press/release debounce,
// column scan with single-key validation, ghost/multi-key error and auto-repeat.
module key_matrix_scan #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int SETTLE_CYC   = 2,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    localparam int CW          = $clog2(ROWS * COLS)
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [ROWS-1:0] Row_i,
    output logic [COLS-1:0] Col_o,
    output logic            Key_flag,
    output logic            Key_repeat,
    output logic [CW-1:0]   Key_code,
    output logic            Key_held,
    output logic            Key_release,
    output logic            Key_err
);

    localparam int MAX_AB  = (DEBOUNCE_CYC > SETTLE_CYC) ? DEBOUNCE_CYC : SETTLE_CYC;
    localparam int MAX_CD  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int COL_W   = $clog2(COLS);
    localparam int ZW      = $clog2(ROWS * COLS + 1);

    // The detecting cycle in IDLE/HOLD counts as the first debounce cycle.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 2);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REPEAT_RATE - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 1);

    typedef enum logic [2:0] {IDLE, P_FILTER, SCAN, RESULT, HOLD, R_FILTER} state_t;

    state_t                     state_q, state_d;
    logic [ROWS-1:0]            row_s1_q, row_s1_d;
    logic [ROWS-1:0]            row_s_q, row_s_d;
    logic [CNT_W-1:0]           deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0]           rep_cnt_q, rep_cnt_d;
    logic                       rep_first_q, rep_first_d;
    logic [COL_W-1:0]           col_idx_q, col_idx_d;
    logic [COLS-1:0]            col_q, col_d;
    logic [COLS-1:0][ROWS-1:0]  hit_q, hit_d;
    logic [CW-1:0]              code_q, code_d;
    logic                       flag_q, flag_d;
    logic                       repeat_q, repeat_d;
    logic                       held_q, held_d;
    logic                       release_q, release_d;
    logic                       err_q, err_d;

    logic                       any_low;
    logic [ZW-1:0]              zero_cnt;
    logic [CW-1:0]              found_code;
    logic [CNT_W-1:0]           rep_last;

    assign any_low  = ~&row_s_q;
    assign rep_last = rep_first_q ? DELAY_LAST : RATE_LAST;

    always_comb begin
        zero_cnt   = '0;
        found_code = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!hit_q[c][r]) begin
                    zero_cnt   = zero_cnt + ZW'(1);
                    found_code = CW'(r * COLS + c);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_s1_d    = Row_i;
        row_s_d     = row_s1_q;
        deb_cnt_d   = deb_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        col_idx_d   = col_idx_q;
        col_d       = col_q;
        hit_d       = hit_q;
        code_d      = code_q;
        flag_d      = 1'b0;
        repeat_d    = 1'b0;
        held_d      = held_q;
        release_d   = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                col_d = '0;
                if (any_low) begin
                    state_d   = P_FILTER;
                    deb_cnt_d = '0;
                end
            end
            P_FILTER: begin
                if (!any_low) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = SCAN;
                    deb_cnt_d = '0;
                    col_idx_d = '0;
                    col_d     = ~COLS'(1);
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            SCAN: begin
                if (deb_cnt_q == SETTLE_LAST) begin
                    // Capture the value Row_s loads on this edge so hit[] acts as a
                    // parallel second synchroniser stage for the driven column.
                    hit_d[col_idx_q] = row_s1_q;
                    deb_cnt_d        = '0;
                    if (col_idx_q == COL_LAST) begin
                        state_d = RESULT;
                        col_d   = '0;
                    end else begin
                        col_idx_d = col_idx_q + COL_W'(1);
                        col_d     = ~(COLS'(1) << (col_idx_q + COL_W'(1)));
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            RESULT: begin
                state_d = HOLD;
                if (zero_cnt == ZW'(1)) begin
                    flag_d      = 1'b1;
                    code_d      = found_code;
                    held_d      = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            HOLD: begin
                col_d = '0;
                if (!any_low) begin
                    state_d   = R_FILTER;
                    deb_cnt_d = '0;
                end else if (REPEAT_EN != 0 && held_q) begin
                    if (rep_cnt_q == rep_last) begin
                        flag_d      = 1'b1;
                        repeat_d    = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_W'(1);
                    end
                end
            end
            R_FILTER: begin
                if (any_low) begin
                    state_d = HOLD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    if (held_q) begin
                        release_d = 1'b1;
                        held_d    = 1'b0;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            row_s1_q    <= '1;
            row_s_q     <= '1;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            col_idx_q   <= '0;
            col_q       <= '0;
            hit_q       <= '1;
            code_q      <= '0;
            flag_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            release_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_s1_q    <= row_s1_d;
            row_s_q     <= row_s_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            hit_q       <= hit_d;
            code_q      <= code_d;
            flag_q      <= flag_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            release_q   <= release_d;
            err_q       <= err_d;
        end
    end

    assign Col_o       = col_q;
    assign Key_flag    = flag_q;
    assign Key_repeat  = repeat_q;
    assign Key_code    = code_q;
    assign Key_held    = held_q;
    assign Key_release = release_q;
    assign Key_err     = err_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: 4x4 plain, 4x4 auto-repeat and 2x3 builds,
// each driven by a small keypad model that pulls a row low through a closed key.
module tb_key_matrix_scan;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // main 4x4 instance, no repeat
    logic [3:0][3:0] keys_m;
    logic [3:0] row_m, col_m;
    logic flag_m_o, rep_m_o, held_m_o, rel_m_o, err_m_o;
    logic [3:0] code_m;

    // 4x4 instance with auto-repeat
    logic [3:0][3:0] keys_r;
    logic [3:0] row_r, col_r;
    logic flag_r_o, rep_r_o, held_r_o, rel_r_o, err_r_o;
    logic [3:0] code_r;

    // 2x3 instance
    logic [1:0][2:0] keys_s;
    logic [1:0] row_s;
    logic [2:0] col_s;
    logic flag_s_o, rep_s_o, held_s_o, rel_s_o, err_s_o;
    logic [2:0] code_s;

    always_comb begin
        for (int r = 0; r < 4; r++) row_m[r] = ~|(keys_m[r] & ~col_m);
        for (int r = 0; r < 4; r++) row_r[r] = ~|(keys_r[r] & ~col_r);
        for (int r = 0; r < 2; r++) row_s[r] = ~|(keys_s[r] & ~col_s);
    end

    key_matrix_scan #(.ROWS(4), .COLS(4), .DEBOUNCE_CYC(16), .SETTLE_CYC(2),
                      .REPEAT_EN(0), .REPEAT_DELAY(64), .REPEAT_RATE(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Row_i(row_m), .Col_o(col_m),
        .Key_flag(flag_m_o), .Key_repeat(rep_m_o), .Key_code(code_m),
        .Key_held(held_m_o), .Key_release(rel_m_o), .Key_err(err_m_o));

    key_matrix_scan #(.ROWS(4), .COLS(4), .DEBOUNCE_CYC(16), .SETTLE_CYC(2),
                      .REPEAT_EN(1), .REPEAT_DELAY(64), .REPEAT_RATE(16)) dut_r (
        .Clk(Clk), .Rst_n(Rst_n), .Row_i(row_r), .Col_o(col_r),
        .Key_flag(flag_r_o), .Key_repeat(rep_r_o), .Key_code(code_r),
        .Key_held(held_r_o), .Key_release(rel_r_o), .Key_err(err_r_o));

    key_matrix_scan #(.ROWS(2), .COLS(3), .DEBOUNCE_CYC(16), .SETTLE_CYC(2),
                      .REPEAT_EN(0), .REPEAT_DELAY(64), .REPEAT_RATE(16)) dut_s (
        .Clk(Clk), .Rst_n(Rst_n), .Row_i(row_s), .Col_o(col_s),
        .Key_flag(flag_s_o), .Key_repeat(rep_s_o), .Key_code(code_s),
        .Key_held(held_s_o), .Key_release(rel_s_o), .Key_err(err_s_o));

    int flag_m = 0, err_m = 0, rel_m = 0, both_m = 0;
    int flag_s = 0, rel_r = 0, orphan_rep = 0;
    int flag_t[$];
    int rep_t[$];
    int code_t[$];
    int col_seq[$];
    logic [2:0] last_col_s = '0;

    always @(negedge Clk) begin
        cyc <= cyc + 1;
        if (flag_m_o === 1'b1) flag_m <= flag_m + 1;
        if (err_m_o === 1'b1) err_m <= err_m + 1;
        if (rel_m_o === 1'b1) rel_m <= rel_m + 1;
        if (flag_m_o === 1'b1 && err_m_o === 1'b1) both_m <= both_m + 1;
        if (flag_s_o === 1'b1) flag_s <= flag_s + 1;
        if (rel_r_o === 1'b1) rel_r <= rel_r + 1;
        if (rep_r_o === 1'b1 && flag_r_o !== 1'b1) orphan_rep <= orphan_rep + 1;
        if (flag_r_o === 1'b1) begin
            flag_t.push_back(cyc + 1);
            rep_t.push_back(int'(rep_r_o));
            code_t.push_back(int'(code_r));
        end
        if (col_s !== 3'b000 && col_s !== last_col_s && !$isunknown(col_s))
            col_seq.push_back(int'(col_s));
        last_col_s <= col_s;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic applyStimulus(input int r, input int c, input logic v, input int n);
        keys_m[r][c] = v;
        waitCycles(n);
    endtask

    int f0, e0, r0, k;
    logic seen;
    int exp_off[7] = '{0, 64, 80, 96, 112, 128, 144};
    int exp_rep[7] = '{0, 1, 1, 1, 1, 1, 1};
    int exp_col[3] = '{6, 5, 3};

    initial begin
        Rst_n  = 1'b0;
        keys_m = '0;
        keys_r = '0;
        keys_s = '0;
        waitCycles(3);
        checkOutput("rst_col", 32'(col_m), 0);
        checkOutput("rst_code", 32'(code_m), 0);
        checkOutput("rst_held", 32'(held_m_o), 0);
        checkOutput("rst_pulses", 32'({flag_m_o, rep_m_o, rel_m_o, err_m_o}), 0);
        Rst_n = 1'b1;
        waitCycles(5);

        $display("[TB] test 1: bouncy press of (2,1)");
        f0 = flag_m; e0 = err_m; r0 = rel_m;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, 1, 1'b1, 3);
            applyStimulus(2, 1, 1'b0, 3);
        end
        applyStimulus(2, 1, 1'b1, 200);
        checkOutput("t1_flags", 32'(flag_m - f0), 1);
        checkOutput("t1_code", 32'(code_m), 9);
        checkOutput("t1_held", 32'(held_m_o), 1);
        checkOutput("t1_no_early_rel", 32'(rel_m - r0), 0);
        keys_m[2][1] = 1'b0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (rel_m_o === 1'b1) begin
                k = i;
                break;
            end
        end
        checkOutput("t1_rel_latency", 32'(k), 18);
        waitCycles(5);
        checkOutput("t1_held_cleared", 32'(held_m_o), 0);
        checkOutput("t1_rel_count", 32'(rel_m - r0), 1);
        checkOutput("t1_no_err", 32'(err_m - e0), 0);

        $display("[TB] test 2: 8-cycle row glitch");
        f0 = flag_m; e0 = err_m; r0 = rel_m;
        applyStimulus(0, 0, 1'b1, 8);
        applyStimulus(0, 0, 1'b0, 30);
        checkOutput("t2_pulses", 32'((flag_m - f0) + (err_m - e0) + (rel_m - r0)), 0);
        checkOutput("t2_col", 32'(col_m), 0);
        checkOutput("t2_held", 32'(held_m_o), 0);

        $display("[TB] test 3: two keys in column 3");
        f0 = flag_m; e0 = err_m; r0 = rel_m;
        keys_m[1][3] = 1'b1;
        applyStimulus(0, 3, 1'b1, 60);
        checkOutput("t3_err", 32'(err_m - e0), 1);
        checkOutput("t3_no_flag", 32'(flag_m - f0), 0);
        checkOutput("t3_code_kept", 32'(code_m), 9);
        keys_m[1][3] = 1'b0;
        applyStimulus(0, 3, 1'b0, 40);
        checkOutput("t3_no_rel", 32'(rel_m - r0), 0);
        checkOutput("t3_held", 32'(held_m_o), 0);

        $display("[TB] test 4: auto-repeat on (3,3)");
        keys_r[3][3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (flag_r_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t4_first_flag_seen", 32'(seen), 1);
        waitCycles(150);
        keys_r[3][3] = 1'b0;
        waitCycles(40);
        checkOutput("t4_flag_count", 32'(flag_t.size()), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < flag_t.size()) begin
                checkOutput($sformatf("t4_offset%0d", i), 32'(flag_t[i] - flag_t[0]), 32'(exp_off[i]));
                checkOutput($sformatf("t4_repeat%0d", i), 32'(rep_t[i]), 32'(exp_rep[i]));
                checkOutput($sformatf("t4_code%0d", i), 32'(code_t[i]), 15);
            end
        end
        checkOutput("t4_orphan_repeat", 32'(orphan_rep), 0);
        checkOutput("t4_release", 32'(rel_r), 1);

        $display("[TB] test 6: 2x3 build, key (1,2)");
        f0 = flag_s;
        keys_s[1][2] = 1'b1;
        waitCycles(60);
        checkOutput("t6_flags", 32'(flag_s - f0), 1);
        checkOutput("t6_code", 32'(code_s), 5);
        checkOutput("t6_col_steps", 32'(col_seq.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < col_seq.size())
                checkOutput($sformatf("t6_col%0d", i), 32'(col_seq[i]), 32'(exp_col[i]));
        end
        keys_s[1][2] = 1'b0;
        waitCycles(40);

        $display("[TB] test 5: reset during scan of column 2");
        keys_m[1][1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (col_m === 4'b1011) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t5_reached_col2", 32'(seen), 1);
        Rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_col", 32'(col_m), 0);
        checkOutput("t5_rst_code", 32'(code_m), 0);
        checkOutput("t5_rst_held", 32'(held_m_o), 0);
        checkOutput("t5_rst_pulses", 32'({flag_m_o, rep_m_o, rel_m_o, err_m_o}), 0);
        keys_m[1][1] = 1'b0;
        waitCycles(3);
        Rst_n = 1'b1;
        waitCycles(5);
        f0 = flag_m;
        applyStimulus(1, 1, 1'b1, 60);
        checkOutput("t5_flag", 32'(flag_m - f0), 1);
        checkOutput("t5_code", 32'(code_m), 5);
        checkOutput("t5_held", 32'(held_m_o), 1);
        applyStimulus(1, 1, 1'b0, 40);
        checkOutput("t5_released", 32'(held_m_o), 0);
        checkOutput("flag_err_overlap", 32'(both_m), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
